// File: rtl/eim_bus_frontend.sv
// eim_bus_frontend
// Synchronising front-end between the i.MX EIM pins and the on-FPGA
// register/memory space. The asynchronous EIM strobes and the DA bus are
// oversampled in the clk48 domain, an FSM decodes address/read/write phases
// and single-cycle read/write strobes are issued towards the memory.
//
// Build option:
//   EIM_FE_BURST_EN - when defined, a finished read or write beat with CS
//                     still asserted returns to ADDR and auto-increments
//                     bus_addr, so consecutive beats need no new LBA cycle.
//
// Bus handshake: bus_rd_stb is a one-cycle request; bus_rd_valid qualifies
// bus_rdata and may be high in the same cycle as bus_rd_stb or any later
// cycle. bus_wr_stb is a one-cycle pulse with bus_addr/bus_wdata valid in
// that same cycle; the memory has no backpressure on writes.
module eim_bus_frontend #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int RD_TIMEOUT  = 255
) (
  input  logic              clk48,
  input  logic              rst,
  input  logic              eim_cs0_n,
  input  logic              eim_lba_n,
  input  logic              eim_wr_n,
  input  logic              eim_oe_n,
  input  logic [DATA_W-1:0] da_in,
  output logic [DATA_W-1:0] da_out,
  output logic              da_oe,
  output logic              eim_wait_n,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_wr_stb,
  output logic              bus_rd_stb,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rd_valid,
  output logic              err_timeout,
  output logic [2:0]        dbg_state_o
);

`ifdef EIM_FE_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_RD_DRIVE = 3'd3,
    ST_WR_DATA  = 3'd4
  } state_e;

  // Strobe bit order inside the synchroniser vectors: {cs, lba, wr, oe}.
  logic [3:0]        strb_sync_q [SYNC_STAGES];
  logic [DATA_W-1:0] da_sync_q   [SYNC_STAGES];
  logic [3:0]        strb_s;
  logic [DATA_W-1:0] da_s;

  // Levels delayed by one so they line up with the registered edge flags.
  logic [3:0] strb_lvl_q;
  logic       cs_l, lba_l, oe_l;
  logic       lba_fall_q, wr_fall_q, oe_fall_q;
  logic       cs_rise_q, wr_rise_q, oe_rise_q;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  da_out_q, da_out_d;
  logic               wr_stb_q, wr_stb_d;
  logic               inc_q, inc_d;

  logic abort, cnt_hit, wr_go, rd_go, rd_done, to_hit, beat_end;

  // Pin synchronisers: strobes idle high, data idles at zero.
  always_ff @(posedge clk48) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        strb_sync_q[i] <= '1;
        da_sync_q[i]   <= '0;
      end
    end else begin
      strb_sync_q[0] <= {eim_cs0_n, eim_lba_n, eim_wr_n, eim_oe_n};
      da_sync_q[0]   <= da_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        strb_sync_q[i] <= strb_sync_q[i-1];
        da_sync_q[i]   <= da_sync_q[i-1];
      end
    end
  end

  assign strb_s = strb_sync_q[SYNC_STAGES-1];
  assign da_s   = da_sync_q[SYNC_STAGES-1];

  // Edge detection: one-cycle rise/fall flags plus matching delayed levels.
  always_ff @(posedge clk48) begin
    if (rst) begin
      strb_lvl_q <= '1;
      lba_fall_q <= 1'b0;
      wr_fall_q  <= 1'b0;
      oe_fall_q  <= 1'b0;
      cs_rise_q  <= 1'b0;
      wr_rise_q  <= 1'b0;
      oe_rise_q  <= 1'b0;
    end else begin
      strb_lvl_q <= strb_s;
      lba_fall_q <=  strb_lvl_q[2] & ~strb_s[2];
      wr_fall_q  <=  strb_lvl_q[1] & ~strb_s[1];
      oe_fall_q  <=  strb_lvl_q[0] & ~strb_s[0];
      cs_rise_q  <= ~strb_lvl_q[3] &  strb_s[3];
      wr_rise_q  <= ~strb_lvl_q[1] &  strb_s[1];
      oe_rise_q  <= ~strb_lvl_q[0] &  strb_s[0];
    end
  end

  assign cs_l  = strb_lvl_q[3];
  assign lba_l = strb_lvl_q[2];
  assign oe_l  = strb_lvl_q[0];

  // Decode terms shared by the FSM and the datapath. A CS release beats
  // every other event in the same cycle; a write fall beats a read fall.
  assign abort    = cs_rise_q && (state_q != ST_IDLE);
  assign cnt_hit  = (cnt_q == CNT_W'(RD_TIMEOUT));
  assign wr_go    = (state_q == ST_ADDR) && !abort && !lba_fall_q && lba_l && wr_fall_q;
  assign rd_go    = (state_q == ST_ADDR) && !abort && !lba_fall_q && lba_l && oe_fall_q
                    && !wr_fall_q;
  assign rd_done  = (state_q == ST_RD_WAIT) && !abort && (bus_rd_valid || cnt_hit);
  assign to_hit   = (state_q == ST_RD_WAIT) && !abort && !bus_rd_valid && cnt_hit;
  assign beat_end = !abort && (((state_q == ST_RD_DRIVE) && oe_rise_q) ||
                               ((state_q == ST_WR_DATA)  && wr_rise_q));

  // FSM state register.
  always_ff @(posedge clk48) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state decode.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (!cs_l && lba_fall_q) state_d = ST_ADDR;
        ST_ADDR: begin
          if (wr_go)      state_d = ST_WR_DATA;
          else if (rd_go) state_d = bus_rd_valid ? ST_RD_DRIVE : ST_RD_WAIT;
        end
        ST_RD_WAIT:  if (rd_done) state_d = ST_RD_DRIVE;
        ST_RD_DRIVE,
        ST_WR_DATA:  if (beat_end) state_d = (BURST && !cs_l) ? ST_ADDR : ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: pad control, wait and the single-cycle request/error pulses.
  always_comb begin
    da_oe       = (state_q == ST_RD_DRIVE) && !oe_l;
    eim_wait_n  = (state_q != ST_RD_WAIT);
    bus_rd_stb  = rd_go;
    err_timeout = to_hit;
    dbg_state_o = state_q;
  end

  // Datapath next-state: address latch, write data, read return, counter.
  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    da_out_d = da_out_q;
    wr_stb_d = 1'b0;
    inc_d    = 1'b0;
    cnt_d    = '0;

    // Burst increment lands one cycle after the beat so the write strobe
    // still carries the address of the beat it belongs to.
    if (inc_q && (state_q == ST_ADDR) && !lba_fall_q) addr_d = addr_q + 1'b1;

    if (!abort) begin
      case (state_q)
        ST_IDLE: if (!cs_l && lba_fall_q) addr_d = da_s[ADDR_W-1:0];
        ST_ADDR: begin
          if (lba_fall_q)                 addr_d   = da_s[ADDR_W-1:0];
          if (rd_go && bus_rd_valid)      da_out_d = bus_rdata;
        end
        ST_RD_WAIT: begin
          if (bus_rd_valid)               da_out_d = bus_rdata;
          else if (cnt_hit)               da_out_d = {DATA_W{1'b1}};
          else                            cnt_d    = cnt_q + 1'b1;
        end
        ST_WR_DATA: begin
          if (wr_rise_q) begin
            wdata_d  = da_s;
            wr_stb_d = 1'b1;
          end
        end
        default: ;
      endcase
      if (beat_end && BURST && !cs_l) inc_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk48) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      da_out_q <= '0;
      wr_stb_q <= 1'b0;
      inc_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      da_out_q <= da_out_d;
      wr_stb_q <= wr_stb_d;
      inc_q    <= inc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_wr_stb = wr_stb_q;
  assign da_out     = da_out_q;

endmodule
